// File: rtl/alu_result_sel.sv
// ALU result selector with a 2-entry skid buffer on the output handshake.
// Optional zero/negative flag storage is enabled by defining ALU_RESULT_SEL_FLAGS_EN.
module alu_result_sel #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 8,
  parameter int SEL_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_OPS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_err,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              xfer_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic [15:0]       xfer_cnt_reg;

  logic [WIDTH-1:0]  main_data_reg, skid_data_reg;
  logic [SEL_W-1:0]  main_sel_reg, skid_sel_reg;
  logic              main_err_reg, skid_err_reg;

  logic [WIDTH-1:0]  ops [NUM_OPS];
  logic [WIDTH-1:0]  cap_data;
  logic              cap_err;
  logic              accept, deliver;
  logic              load_main, load_skid, move_skid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_ops
      assign ops[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Out-of-range select codes fall through the loop and capture zero with err set.
  always_comb begin
    cap_data = '0;
    cap_err  = 1'b1;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (sel == SEL_W'(k)) begin
        cap_data = ops[k];
        cap_err  = 1'b0;
      end
    end
  end

  assign accept    = in_valid && in_ready_reg;
  assign deliver   = out_valid_reg && out_ready;
  assign load_main = accept && ((state_reg == EMPTY) || ((state_reg == ONE) && deliver));
  assign load_skid = accept && (state_reg == ONE) && !deliver;
  assign move_skid = (state_reg == TWO) && deliver;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      xfer_cnt_reg  <= 16'd0;
    end else begin
      in_ready_reg <= 1'b1;
      if (accept) xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_reg     <= ONE;
            out_valid_reg <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !deliver) begin
            state_reg    <= TWO;
            in_ready_reg <= 1'b0;
          end else if (deliver && !accept) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
          end
        end
        TWO: begin
          if (deliver) state_reg <= ONE;
          else         in_ready_reg <= 1'b0;
        end
        default: begin
          state_reg     <= EMPTY;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_reg <= '0;
      main_sel_reg  <= '0;
      main_err_reg  <= 1'b0;
      skid_data_reg <= '0;
      skid_sel_reg  <= '0;
      skid_err_reg  <= 1'b0;
    end else begin
      if (load_main) begin
        main_data_reg <= cap_data;
        main_sel_reg  <= sel;
        main_err_reg  <= cap_err;
      end else if (move_skid) begin
        main_data_reg <= skid_data_reg;
        main_sel_reg  <= skid_sel_reg;
        main_err_reg  <= skid_err_reg;
      end
      if (load_skid) begin
        skid_data_reg <= cap_data;
        skid_sel_reg  <= sel;
        skid_err_reg  <= cap_err;
      end
    end
  end

`ifdef ALU_RESULT_SEL_FLAGS_EN
  // Flags travel with their entry so they never depend on out_data combinationally.
  logic main_zero_reg, main_neg_reg, skid_zero_reg, skid_neg_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_zero_reg <= 1'b0;
      main_neg_reg  <= 1'b0;
      skid_zero_reg <= 1'b0;
      skid_neg_reg  <= 1'b0;
    end else begin
      if (load_main) begin
        main_zero_reg <= (cap_data == '0);
        main_neg_reg  <= cap_data[WIDTH-1];
      end else if (move_skid) begin
        main_zero_reg <= skid_zero_reg;
        main_neg_reg  <= skid_neg_reg;
      end
      if (load_skid) begin
        skid_zero_reg <= (cap_data == '0);
        skid_neg_reg  <= cap_data[WIDTH-1];
      end
    end
  end

  assign out_zero = main_zero_reg;
  assign out_neg  = main_neg_reg;
`else
  assign out_zero = 1'b0;
  assign out_neg  = 1'b0;
`endif

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = main_data_reg;
  assign out_sel   = main_sel_reg;
  assign out_err   = main_err_reg;
  assign xfer_cnt  = xfer_cnt_reg;

endmodule
